// File: rtl/temp_digit_formatter.sv
// Samples Celsius/Fahrenheit readings on a slow tick, filters I2C glitches, and
// converts accepted readings to sign + 3 BCD digits with a serial double-dabble engine.

module dd_adj3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

module temp_digit_formatter #(
    parameter int SAMPLE_DIV = 2_500_000,
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] c_val,
    input  logic [7:0] f_val,
    output logic       c_sign,
    output logic [3:0] c_hund,
    output logic [3:0] c_tens,
    output logic [3:0] c_ones,
    output logic [3:0] f_hund,
    output logic [3:0] f_tens,
    output logic [3:0] f_ones,
    output logic       digits_valid,
    output logic       update,
    output logic       busy
);
    localparam int                CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [3:0]        STABLE_C = 4'(STABLE_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_C = 2'd1,
        CONV_F = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_tick_cnt;
    logic              w_tick;
    logic              r_tick_d;
    logic [7:0]        r_c_smp;
    logic [7:0]        r_f_smp;
    logic [3:0]        r_match;

    logic [7:0]        r_c_lat;
    logic [7:0]        r_f_lat;
    logic              r_neg;
    logic [7:0]        r_c_disp;
    logic [7:0]        r_f_disp;
    logic              r_first_done;

    logic [11:0]       r_bcd;
    logic [7:0]        r_src;
    logic [2:0]        r_bit_cnt;
    logic [11:0]       r_c_bcd;
    logic [7:0]        w_bcd_adj;
    logic [11:0]       w_bcd_nxt;
    logic [7:0]        w_src_nxt;
    logic [7:0]        w_c_mag;
    logic              w_last_bit;
    logic              w_accept;

    logic              r_c_sign;
    logic [11:0]       r_c_dig;
    logic [11:0]       r_f_dig;
    logic              r_valid;
    logic              r_update;
    logic              r_busy;

    // ---------------- sample tick and stability filter ----------------
    assign w_tick = (r_tick_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_tick_d   <= 1'b0;
            r_c_smp    <= 8'd0;
            r_f_smp    <= 8'd0;
            r_match    <= 4'd0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            r_tick_d   <= w_tick && (r_state == IDLE);
            if (w_tick && (r_state == IDLE)) begin
                r_c_smp <= c_val;
                r_f_smp <= f_val;
                if ({c_val, f_val} == {r_c_smp, r_f_smp})
                    r_match <= (r_match == 4'd15) ? 4'd15 : r_match + 4'd1;
                else
                    r_match <= 4'd1;
            end
        end
    end

    assign w_accept = (r_state == IDLE) && r_tick_d && (r_match >= STABLE_C) &&
                      (({r_c_smp, r_f_smp} != {r_c_disp, r_f_disp}) || !r_first_done);

    // Two's-complement magnitude; 0x80 naturally yields 128.
    assign w_c_mag = r_c_smp[7] ? (~r_c_smp + 8'd1) : r_c_smp;

    // ---------------- double-dabble step ----------------
    // With 8-bit operands the hundreds nibble never exceeds 2 mid-conversion,
    // so only the tens and ones nibbles need the add-3 correction.
    for (genvar g = 0; g < 2; g++) begin : g_adj
        dd_adj3 u_adj (
            .i_nib (r_bcd[g*4 +: 4]),
            .o_nib (w_bcd_adj[g*4 +: 4])
        );
    end

    assign w_bcd_nxt  = {r_bcd[10:8], w_bcd_adj, r_src[7]};
    assign w_src_nxt  = {r_src[6:0], 1'b0};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = CONV_C;
            CONV_C:  if (w_last_bit) w_state_nxt = CONV_F;
            CONV_F:  if (w_last_bit) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- conversion datapath and output registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_lat      <= 8'd0;
            r_f_lat      <= 8'd0;
            r_neg        <= 1'b0;
            r_bcd        <= 12'd0;
            r_src        <= 8'd0;
            r_bit_cnt    <= 3'd0;
            r_c_bcd      <= 12'd0;
            r_c_disp     <= 8'd0;
            r_f_disp     <= 8'd0;
            r_first_done <= 1'b0;
            r_c_sign     <= 1'b0;
            r_c_dig      <= 12'd0;
            r_f_dig      <= 12'd0;
            r_valid      <= 1'b0;
            r_update     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_update <= 1'b0;
            r_busy   <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_c_lat   <= r_c_smp;
                        r_f_lat   <= r_f_smp;
                        r_neg     <= r_c_smp[7];
                        r_src     <= w_c_mag;
                        r_bcd     <= 12'd0;
                        r_bit_cnt <= 3'd0;
                    end
                end
                CONV_C: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_last_bit) begin
                        // Park the Celsius result and reload the engine with f.
                        r_c_bcd <= w_bcd_nxt;
                        r_bcd   <= 12'd0;
                        r_src   <= r_f_lat;
                    end else begin
                        r_bcd <= w_bcd_nxt;
                        r_src <= w_src_nxt;
                    end
                end
                CONV_F: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_bcd     <= w_bcd_nxt;
                    r_src     <= w_src_nxt;
                end
                LOAD: begin
                    r_c_sign     <= r_neg;
                    r_c_dig      <= r_c_bcd;
                    r_f_dig      <= r_bcd;
                    r_c_disp     <= r_c_lat;
                    r_f_disp     <= r_f_lat;
                    r_first_done <= 1'b1;
                    r_valid      <= 1'b1;
                    r_update     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign c_sign       = r_c_sign;
    assign c_hund       = r_c_dig[11:8];
    assign c_tens       = r_c_dig[7:4];
    assign c_ones       = r_c_dig[3:0];
    assign f_hund       = r_f_dig[11:8];
    assign f_tens       = r_f_dig[7:4];
    assign f_ones       = r_f_dig[3:0];
    assign digits_valid = r_valid;
    assign update       = r_update;
    assign busy         = r_busy;

endmodule

// File: tb/tb_temp_digit_formatter.sv
// Bench for temp_digit_formatter: directed and random readings compared against a
// tick-level model that derives digits with decimal arithmetic.

module tb_temp_digit_formatter;
    localparam int DIV = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] c_val, f_val;
    logic       c_sign, digits_valid, update, busy;
    logic [3:0] c_hund, c_tens, c_ones, f_hund, f_tens, f_ones;

    temp_digit_formatter #(.SAMPLE_DIV(DIV), .STABLE_CNT(3)) dut (
        .clk(clk), .rst(rst), .c_val(c_val), .f_val(f_val),
        .c_sign(c_sign), .c_hund(c_hund), .c_tens(c_tens), .c_ones(c_ones),
        .f_hund(f_hund), .f_tens(f_tens), .f_ones(f_ones),
        .digits_valid(digits_valid), .update(update), .busy(busy)
    );

    always #20 clk = ~clk;

    wire [25:0] obs_vec = {c_sign, c_hund, c_tens, c_ones, f_hund, f_tens, f_ones, digits_valid};

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_prev_c, m_prev_f, m_disp_c, m_disp_f, m_pend_c, m_pend_f;
    int          m_match;
    bit          m_first, m_pend;
    logic [25:0] m_cur_vec, m_pend_vec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] exp_vec(input logic [7:0] c, input logic [7:0] f);
        int cs, mag, fv;
        logic [25:0] v;
        cs  = int'($signed(c));
        mag = (cs < 0) ? -cs : cs;
        fv  = int'(f);
        v = {(cs < 0) ? 1'b1 : 1'b0,
             4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10),
             4'(fv / 100),  4'((fv / 10) % 10),  4'(fv % 10), 1'b1};
        return v;
    endfunction

    task automatic model_reset();
        m_prev_c = 0; m_prev_f = 0; m_disp_c = 0; m_disp_f = 0;
        m_match = 0; m_first = 0; m_pend = 0; m_cur_vec = '0;
    endtask

    task automatic model_capture(input logic [7:0] c, input logic [7:0] f);
        if (c == m_prev_c && f == m_prev_f) m_match = (m_match >= 15) ? 15 : m_match + 1;
        else                                m_match = 1;
        m_prev_c = c; m_prev_f = f;
        m_pend = (m_match >= 3) && ((c != m_disp_c) || (f != m_disp_f) || !m_first);
        if (m_pend) begin
            m_pend_vec = exp_vec(c, f);
            m_pend_c = c; m_pend_f = f;
        end
    endtask

    // One tick period: inputs applied now, sample captured on the 20th edge.
    task automatic run_period(input logic [7:0] c, input logic [7:0] f);
        c_val = c; f_val = f;
        for (int k = 1; k <= DIV; k++) begin
            @(posedge clk); @(negedge clk);
            if (m_pend && k == 18) begin
                m_cur_vec = m_pend_vec;
                m_disp_c = m_pend_c; m_disp_f = m_pend_f; m_first = 1;
            end
            chk("busy",   32'(busy),    32'(m_pend && k <= 17));
            chk("update", 32'(update),  32'(m_pend && k == 18));
            chk("digits", 32'(obs_vec), 32'(m_cur_vec));
        end
        model_capture(c, f);
    endtask

    task automatic hold(input logic [7:0] c, input logic [7:0] f, input int n);
        for (int i = 0; i < n; i++) run_period(c, f);
    endtask

    initial begin
        rst = 1'b0; c_val = 8'h19; f_val = 8'h4D;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_digits", 32'(obs_vec), 32'd0);
        chk("reset_busy",   32'(busy),    32'd0);
        chk("reset_update", 32'(update),  32'd0);
        rst = 1'b1;

        hold(8'h19, 8'h4D, 4);
        chk("c25_f77", 32'(obs_vec), 32'(26'h0025_077 << 1 | 26'd1));
        hold(8'h19, 8'h4D, 10);

        hold(8'hF6, 8'h0E, 4);
        chk("cm10_f14", 32'(obs_vec), 32'({1'b1, 12'h010, 12'h014, 1'b1}));
        hold(8'h80, 8'hFF, 4);
        chk("cm128_f255", 32'(obs_vec), 32'({1'b1, 12'h128, 12'h255, 1'b1}));
        hold(8'h00, 8'hFF, 4);
        chk("c0_f255", 32'(obs_vec), 32'({1'b0, 12'h000, 12'h255, 1'b1}));

        for (int i = 0; i < 10; i++) run_period((i % 2) ? 8'h1A : 8'h19, 8'hFF);
        chk("alt_hold", 32'(obs_vec), 32'({1'b0, 12'h000, 12'h255, 1'b1}));

        for (int r = 0; r < 12; r++) begin
            logic [7:0] rc, rf;
            rc = 8'($urandom_range(0, 255));
            rf = 8'($urandom_range(0, 255));
            hold(rc, rf, $urandom_range(1, 5));
        end

        // Reset in the middle of the Celsius conversion.
        hold(8'h05, 8'h06, 4);
        hold(8'h19, 8'h4D, 3);
        c_val = 8'h19; f_val = 8'h4D;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); @(negedge clk);
            chk("pre_rst_busy", 32'(busy), 32'd1);
        end
        rst = 1'b0;
        #1;
        chk("rst_async_digits", 32'(obs_vec), 32'd0);
        chk("rst_async_busy",   32'(busy),    32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_update", 32'(update), 32'd0);
        end
        model_reset();
        rst = 1'b1;
        hold(8'h19, 8'h4D, 4);
        chk("post_rst_c25_f77", 32'(obs_vec), 32'({1'b0, 12'h025, 12'h077, 1'b1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/temp_digit_formatter.md
Name: temp_digit_formatter

Overview:
- Sits between the I2C temperature path (raw Celsius byte and converted Fahrenheit byte) and the LED panel display controller.
- Samples both readings periodically and rejects I2C glitches with a stability filter.
- Converts accepted readings to sign + 3 BCD digits each, using a sequential double-dabble engine.
- Presents the digits as registered, glitch-free outputs with a one-cycle update strobe for the display stage.

Parameters:
- SAMPLE_DIV, 2_500_000, clocks between sample ticks (100 ms at 25 MHz); legal range 20..2^22-1.
- STABLE_CNT, 3, consecutive identical samples required before a reading is accepted; legal range 1..15.

Ports:
- clk  input  1  25 MHz system clock
- rst  input  1  reset, asynchronous, active-low
- c_val  input  8  Celsius, two's complement signed (-128..127)
- f_val  input  8  Fahrenheit, unsigned (0..255)
- c_sign  output  1  1 = Celsius negative
- c_hund  output  4  Celsius hundreds digit of magnitude, BCD
- c_tens  output  4  Celsius tens digit, BCD
- c_ones  output  4  Celsius ones digit, BCD
- f_hund  output  4  Fahrenheit hundreds digit, BCD
- f_tens  output  4  Fahrenheit tens digit, BCD
- f_ones  output  4  Fahrenheit ones digit, BCD
- digits_valid  output  1  high once the first reading has been accepted
- update  output  1  one-clock pulse when digit outputs change
- busy  output  1  conversion in progress

Behaviour:
- Reset (rst=0, asynchronous): all digit outputs = 0, c_sign = 0, digits_valid = 0, update = 0, busy = 0. Internal state also clears: tick counter = 0, match count = 0, sample regs = 0, FSM = IDLE, "displayed" regs = 0, first_done = 0.
- Tick generation:
  - Free-running counter 0..SAMPLE_DIV-1; tick asserts for one clock when the counter = SAMPLE_DIV-1, then the counter wraps to 0.
  - The counter runs regardless of FSM state.
- Tick processing when FSM = IDLE, on the tick edge:
  - Capture {c_val, f_val} into the sample regs.
  - If the new pair equals the previous sample, match = min(match+1, 15); otherwise match = 1.
- Tick processing when FSM != IDLE: the tick is ignored entirely (no capture, match unchanged).
- Accept condition, evaluated in IDLE on the cycle after a tick, all of:
  - match >= STABLE_CNT;
  - the sample pair differs from the displayed pair, OR first_done = 0.
  - If met: latch the Celsius magnitude (|c|; 0x80 gives 128) and its sign bit, latch f, busy goes to 1, FSM -> CONV_C.
- FSM states:
  - IDLE: waits for the accept condition.
  - CONV_C: exactly 8 clocks. Each clock: every BCD nibble >= 5 gets +3, then the 12-bit BCD accumulator and 8-bit source shift left one bit. Then -> CONV_F.
  - CONV_F: the same 8-clock iteration on f. Then -> LOAD.
  - LOAD: 1 clock. Registers all digit outputs and c_sign, sets displayed pair = accepted pair, sets first_done = 1 and digits_valid = 1, pulses update = 1, drives busy = 0, FSM -> IDLE.
- Latency: the accept edge is followed by 17 clocks; outputs and update change together on the LOAD edge.
- Digit outputs are stable at all other times; no intermediate value ever appears on them.
- Width rules: the BCD accumulator is 12 bits; max inputs 128 and 255 fit in 3 digits. c_hund is only ever 0 or 1.
- Zero: c_val = 0x00 gives c_sign = 0, digits 0,0,0 (no negative zero).
- digits_valid never falls except on reset.
- An unchanged stable reading produces no further update pulses.
- Input changes during CONV_* have no effect; the latched operands are used.
- Reset mid-conversion: outputs clear immediately, no update pulse; a fresh STABLE_CNT run is needed after reset release.

Test Plan (SAMPLE_DIV=20, STABLE_CNT=3):
- Release reset, hold c_val=0x19, f_val=0x4D -> on the 3rd tick the FSM accepts; 17 clocks later update=1 for one clock with c_sign=0, c digits 0,2,5 and f digits 0,7,7; digits_valid=1; busy high exactly 17 clocks.
- After the previous case, hold values for 10 more ticks -> no further update pulse; outputs unchanged.
- c_val=0xF6, f_val=0x0E stable -> c_sign=1, c digits 0,1,0; f digits 0,1,4.
- c_val=0x80, f_val=0xFF stable -> c_sign=1, c digits 1,2,8; f digits 2,5,5; then c_val=0x00 -> c_sign=0, digits 0,0,0.
- Alternate c_val between 0x19 and 0x1A on every tick for 10 ticks -> match never exceeds 1, no update, previous digits held.
- Assert rst low 5 clocks after an accept (mid CONV_C) -> all outputs 0 asynchronously, busy=0, no update; after release, an update occurs only after 3 matching ticks.
